// File: rtl/led_blink_scheduler_pkg.sv
// Shared types and helpers for the LED blink scheduler: FSM state encoding,
// requester geometry and the tick-period calculation.
package led_blink_scheduler_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } blink_state_e;

    function automatic int calc_tick_period(input int clk_khz, input int tick_hz);
        return (clk_khz * 1000) / tick_hz;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_blink_scheduler_tick_gen.sv
// Restartable prescaler: emits a one-cycle tick every TICK_PERIOD clocks,
// counting from the cycle after clr.
module led_tick_gen #(
    parameter int TICK_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [PW-1:0] CNT_LAST = PW'(TICK_PERIOD - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = cnt_q + PW'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin arbiter for four blink requesters sharing one LED; each grant
// plays N on/off blinks followed by a quiet gap before the next arbitration.
module led_blink_scheduler
    import led_blink_scheduler_pkg::*;
#(
    parameter int CLK_FREQ_KHz = 50000,
    parameter int TICK_FREQ_Hz = 10,
    parameter int ON_TICKS     = 2,
    parameter int OFF_TICKS    = 2,
    parameter int GAP_TICKS    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*CNT_W-1:0]  req_count,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      led,
    output logic                      busy,
    output logic [ID_W-1:0]           active_id
);

    localparam int TICK_PERIOD = calc_tick_period(CLK_FREQ_KHz, TICK_FREQ_Hz);
    localparam int MAX_TICKS   = max3(ON_TICKS, OFF_TICKS, GAP_TICKS);
    localparam int TW          = $clog2(MAX_TICKS + 1);

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

    blink_state_e    state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] active_id_q, active_id_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;

    logic            tick;
    logic            phase_clr;
    logic            phase_done;
    logic [TW-1:0]   phase_last;
    logic            grant;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic [CNT_W-1:0] grant_cnt;

    led_tick_gen #(.TICK_PERIOD(TICK_PERIOD)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (phase_clr),
        .tick (tick)
    );

    // Round-robin search starting at ptr; first asserted valid wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + ID_W'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        active_id_d = active_id_q;
        rem_d       = rem_q;
        tcnt_d      = tcnt_q;
        req_ready   = '0;
        grant_cnt   = req_count[{grant_idx, 2'b00} +: CNT_W];
        grant       = (state_q == IDLE) && grant_found && !rst;

        case (state_q)
            ON:      phase_last = ON_LAST;
            OFF:     phase_last = OFF_LAST;
            default: phase_last = GAP_LAST;
        endcase
        phase_done = tick && (tcnt_q == phase_last);
        if (tick) tcnt_d = tcnt_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (grant) begin
                    req_ready[grant_idx] = 1'b1;
                    active_id_d          = grant_idx;
                    ptr_d                = grant_idx + ID_W'(1);
                    rem_d                = grant_cnt;
                    if (grant_cnt != '0) state_d = ON;
                end
            end
            ON:  if (phase_done) state_d = OFF;
            OFF: begin
                if (phase_done) begin
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q > CNT_W'(1)) ? ON : GAP;
                end
            end
            GAP: if (phase_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Every phase change restarts both the prescaler and the tick count.
        phase_clr = (state_d != state_q);
        if (phase_clr) tcnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            active_id_q <= '0;
            rem_q       <= '0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            active_id_q <= active_id_d;
            rem_q       <= rem_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign led       = (state_q == ON);
    assign busy      = (state_q != IDLE);
    assign active_id = grant ? grant_idx : active_id_q;

endmodule
